npu_param_fifo: RTL

- Parametrised synchronous FIFO for the NPU input, config and output queues.
- Replaces the fixed-width, fixed-depth queues: configurable width, depth and read mode.
- Adds occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
- Sits between the host-side write interface and the NPU datapath; one instance per queue.

---
 rtl/npu_fifo_pkg.sv | 10 +
 rtl/npu_fifo_ram.sv | 50 +++++
 rtl/npu_param_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/npu_fifo_pkg.sv
// npu_fifo_pkg
// Shared constants for the NPU queue FIFOs.
//   NPU_FIFO_STD / NPU_FIFO_FWFT : read-mode selectors for the FWFT parameter
//   NPU_DATA_W / NPU_CFG_W       : default word widths for data and config queues
package npu_fifo_pkg;
    localparam int NPU_FIFO_STD  = 0;
    localparam int NPU_FIFO_FWFT = 1;
    localparam int NPU_DATA_W    = 32;
    localparam int NPU_CFG_W     = 26;
endpackage

// File: rtl/npu_fifo_ram.sv
// npu_fifo_ram
// Simple dual-port RAM, WIDTH x 2**ADDR_W, one synchronous write port and one
// read port whose output is either registered (REG_RD=1) or asynchronous
// (REG_RD=0, maps onto distributed RAM).
// Ports:
//   clk, rst          : clock; rst clears only the registered read output
//   we, wr_addr, wr_data : write port
//   rd_en, rd_addr    : read port (rd_en only used by the registered output)
//   rd_data           : read data
module npu_fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int REG_RD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage is never cleared; only the read register has a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            // Read-before-write on an address collision: a pop of a full
            // FIFO that also accepts a push returns the old word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_async_rd
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = rst ^ rd_en;
            assign rd_data        = mem[rd_addr];
        end
    endgenerate
endmodule

// File: rtl/npu_param_fifo.sv
// npu_param_fifo
// Parametrised synchronous FIFO used for the NPU input, config and output
// queues. Occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   wr_en, din    : push request and data
//   rd_en         : pop request
//   err_clr       : clears overflow/underflow (a same-cycle error wins)
//   dout          : read data (registered in standard mode, head word in FWFT)
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : sticky rejected-request flags
//
// Handshake: wr_en/rd_en are requests, not commands. A pop is accepted when
// the FIFO is not empty; a push is accepted when not full, or when full and a
// pop is accepted in the same cycle. Rejected requests change no data state
// and only set the matching sticky error flag.
module npu_param_fifo
    import npu_fifo_pkg::*;
#(
    parameter int WIDTH      = NPU_DATA_W,
    parameter int DEPTH_LOG2 = 4,
    parameter int FWFT       = NPU_FIFO_STD,
    parameter int AF_THRESH  = (2**DEPTH_LOG2) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int                DEPTH     = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    generate
        if (DEPTH_LOG2 < 1 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_params
            $error("npu_param_fifo: illegal DEPTH_LOG2/AF_THRESH/AE_THRESH combination");
        end
    endgenerate

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [WIDTH-1:0]      ram_dout;

    // Flags come from the registered count, never from pointer compare.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers are DEPTH_LOG2 bits wide, so the increment wraps.
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(rd_acc);

            // Clear first so a same-cycle error event overrides it.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    npu_fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2),
        .REG_RD ((FWFT == NPU_FIFO_FWFT) ? 0 : 1)
    ) u_ram (
        .clk     (CLK),
        .rst     (RST),
        .we      (wr_acc && !RST),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_dout)
    );

    generate
        if (FWFT == NPU_FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // uninitialised RAM never reaches the output.
            assign dout = empty ? '0 : ram_dout;
        end else begin : g_std
            assign dout = ram_dout;
        end
    endgenerate
endmodule
